// File: rtl/seg7_scan_capture.sv
// Receive side of the 4-digit 7-segment display link. Watches the multiplexed
// segment bus and one-hot digit enables, accepts a digit once its pattern has
// been stable for STABLE_CYC samples, and publishes all four recovered codes
// together once every digit has been seen.
module seg7_scan_capture #(
  parameter int STABLE_CYC = 4,
  parameter int CNT_W      = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_seg,
  input  logic [3:0] i_dig_en,
  input  logic       i_err_clr,
  output logic [3:0] o_x0,
  output logic [3:0] o_x1,
  output logic [3:0] o_x2,
  output logic [3:0] o_x3,
  output logic       o_frame_valid,
  output logic       o_err
);

  typedef enum logic [1:0] {
    S_WAIT,
    S_SETTLE,
    S_HOLD
  } state_t;

  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYC);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  state_t           r_state;
  state_t           w_stateNext;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cntNext;
  logic [3:0]       r_prevDig;
  logic [6:0]       r_prevSeg;
  logic [3:0]       r_seen;
  logic [3:0]       r_shadow [4];
  logic [3:0]       r_x [4];
  logic             r_frameValid;
  logic             r_err;

  logic             w_oneHot;
  logic             w_same;
  logic [1:0]       w_idx;
  logic [3:0]       w_code;
  logic             w_bad;
  logic             w_capture;
  logic [3:0]       w_seenNext;
  logic [3:0]       w_merged [4];

  // Classify the current sample: one-hot check, repeat detection, digit index and segment decode
  always_comb begin
    w_oneHot = (i_dig_en != 4'd0) && ((i_dig_en & (i_dig_en - 4'd1)) == 4'd0);
    w_same   = w_oneHot && (i_dig_en == r_prevDig) && (i_seg == r_prevSeg);
    w_idx    = 2'd0;
    case (i_dig_en)
      4'b0010: w_idx = 2'd1;
      4'b0100: w_idx = 2'd2;
      4'b1000: w_idx = 2'd3;
      default: w_idx = 2'd0;
    endcase
    w_bad  = 1'b0;
    w_code = 4'hE;
    case (i_seg)
      7'b1111110: w_code = 4'd0;
      7'b0110000: w_code = 4'd1;
      7'b1101101: w_code = 4'd2;
      7'b1111001: w_code = 4'd3;
      7'b0110011: w_code = 4'd4;
      7'b1011011: w_code = 4'd5;
      7'b1011111: w_code = 4'd6;
      7'b1110000: w_code = 4'd7;
      7'b1111111: w_code = 4'd8;
      7'b1111011: w_code = 4'd9;
      7'b0000001: w_code = 4'hF;
      7'b0000000: w_code = 4'hD;
      default: begin
        w_code = 4'hE;
        w_bad  = 1'b1;
      end
    endcase
  end

  // Stability FSM: a new one-hot sample restarts the count, a repeat advances it, capture fires once per run
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_capture   = 1'b0;
    if (!w_oneHot) begin
      w_stateNext = S_WAIT;
      w_cntNext   = '0;
    end else if ((r_state == S_WAIT) || !w_same) begin
      w_cntNext = ONE_C;
      if (STABLE_CYC == 1) begin
        w_capture   = 1'b1;
        w_stateNext = S_HOLD;
      end else begin
        w_stateNext = S_SETTLE;
      end
    end else if (r_state == S_SETTLE) begin
      if (r_cnt >= STABLE_C - ONE_C) begin
        w_cntNext   = STABLE_C;
        w_capture   = 1'b1;
        w_stateNext = S_HOLD;
      end else begin
        w_cntNext = r_cnt + ONE_C;
      end
    end
  end

  // Frame assembly view: the seen mask after this capture and the shadows with this digit merged in
  always_comb begin
    w_seenNext = r_seen | (4'd1 << w_idx);
    for (int i = 0; i < 4; i++) begin
      w_merged[i] = (w_idx == 2'(i)) ? w_code : r_shadow[i];
    end
  end

  // State and stability counter registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_WAIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end

  // Previous sample, shadow capture, frame publish and sticky error flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prevDig    <= 4'd0;
      r_prevSeg    <= 7'd0;
      r_seen       <= 4'd0;
      r_frameValid <= 1'b0;
      r_err        <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_shadow[i] <= 4'hF;
        r_x[i]      <= 4'hF;
      end
    end else begin
      r_prevDig    <= i_dig_en;
      r_prevSeg    <= i_seg;
      r_frameValid <= 1'b0;
      if (w_capture) begin
        r_shadow[w_idx] <= w_code;
        if (w_seenNext == 4'hF) begin
          for (int i = 0; i < 4; i++) begin
            r_x[i] <= w_merged[i];
          end
          r_seen       <= 4'd0;
          r_frameValid <= 1'b1;
        end else begin
          r_seen <= w_seenNext;
        end
      end
      if (w_capture && w_bad) begin
        r_err <= 1'b1;
      end else if (i_err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign o_x0          = r_x[0];
  assign o_x1          = r_x[1];
  assign o_x2          = r_x[2];
  assign o_x3          = r_x[3];
  assign o_frame_valid = r_frameValid;
  assign o_err         = r_err;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Bench for seg7_scan_capture: table-driven scans, hand-written corner
// sequences and randomized traffic, all compared each cycle against a
// run-length reference model of the capture rules.
module tb_seg7_scan_capture;

  localparam int STABLE = 4;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [6:0] i_seg = 7'd0;
  logic [3:0] i_dig_en = 4'd0;
  logic       i_err_clr = 1'b0;
  logic [3:0] o_x0, o_x1, o_x2, o_x3;
  logic       o_frame_valid;
  logic       o_err;

  seg7_scan_capture #(.STABLE_CYC(STABLE), .CNT_W(8)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_seg        (i_seg),
    .i_dig_en     (i_dig_en),
    .i_err_clr    (i_err_clr),
    .o_x0         (o_x0),
    .o_x1         (o_x1),
    .o_x2         (o_x2),
    .o_x3         (o_x3),
    .o_frame_valid(o_frame_valid),
    .o_err        (o_err)
  );

  // Free-running clock
  always #5 i_clk = ~i_clk;

  typedef struct {
    int          c0, c1, c2, c3;
    int          hold;
    logic [15:0] expX;
    logic        expErr;
    int          expFrames;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  int         frameCnt = 0;
  logic [6:0] pats [13];
  logic [3:0] codes [12];
  vec_t       vecs [6];

  // Reference model state: length of the current run of identical one-hot samples
  int         mRun;
  logic [3:0] mPrevDig;
  logic [6:0] mPrevSeg;
  logic [3:0] mSeen;
  logic [3:0] mShadow [4];
  logic [3:0] mX [4];
  logic       mFv;
  logic       mErr;

  function automatic logic [3:0] refDecode(input logic [6:0] s);
    for (int i = 0; i < 12; i++) begin
      if (pats[i] == s) return codes[i];
    end
    return 4'hE;
  endfunction

  function automatic int digIndex(input logic [3:0] d);
    for (int i = 0; i < 4; i++) begin
      if (d[i]) return i;
    end
    return 0;
  endfunction

  task automatic modelStep(input logic [3:0] d, input logic [6:0] s, input logic clr, input logic r);
    logic       bad;
    logic [3:0] code;
    int         idx;
    mFv = 1'b0;
    bad = 1'b0;
    if (r) begin
      mRun  = 0;
      mSeen = 4'd0;
      mErr  = 1'b0;
      for (int i = 0; i < 4; i++) begin
        mShadow[i] = 4'hF;
        mX[i]      = 4'hF;
      end
      return;
    end
    if ($countones(d) != 1) begin
      mRun = 0;
    end else begin
      if (mRun > 0 && d == mPrevDig && s == mPrevSeg) begin
        if (mRun < 1000) mRun++;
      end else begin
        mRun = 1;
      end
      if (mRun == STABLE) begin
        idx          = digIndex(d);
        code         = refDecode(s);
        bad          = (code == 4'hE);
        mShadow[idx] = code;
        mSeen[idx]   = 1'b1;
        if (mSeen == 4'hF) begin
          for (int i = 0; i < 4; i++) mX[i] = mShadow[i];
          mSeen = 4'd0;
          mFv   = 1'b1;
        end
      end
    end
    mPrevDig = d;
    mPrevSeg = s;
    if (bad) mErr = 1'b1;
    else if (clr) mErr = 1'b0;
  endtask

  task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic checkOutput(input string name);
    checkVal(name, {14'd0, o_x3, o_x2, o_x1, o_x0, o_frame_valid, o_err},
             {14'd0, mX[3], mX[2], mX[1], mX[0], mFv, mErr});
  endtask

  task automatic applyStimulus(input logic [3:0] d, input logic [6:0] s, input logic clr, input logic r);
    i_dig_en  = d;
    i_seg     = s;
    i_err_clr = clr;
    i_rst     = r;
    @(posedge i_clk);
    modelStep(d, s, clr, r);
    #1;
    if (o_frame_valid === 1'b1) frameCnt++;
    checkOutput("cycle");
  endtask

  task automatic holdDigit(input int dig, input int pat, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      applyStimulus(4'd1 << dig, pats[pat], 1'b0, 1'b0);
    end
  endtask

  task automatic scanDigits(input int c0, input int c1, input int c2, input int c3, input int hold);
    frameCnt = 0;
    holdDigit(0, c0, hold);
    holdDigit(1, c1, hold);
    holdDigit(2, c2, hold);
    holdDigit(3, c3, hold);
  endtask

  // Test sequence
  initial begin
    logic [3:0] rd;
    logic [6:0] rs;
    int         hl;

    pats[0]  = 7'b1111110; pats[1]  = 7'b0110000; pats[2]  = 7'b1101101;
    pats[3]  = 7'b1111001; pats[4]  = 7'b0110011; pats[5]  = 7'b1011011;
    pats[6]  = 7'b1011111; pats[7]  = 7'b1110000; pats[8]  = 7'b1111111;
    pats[9]  = 7'b1111011; pats[10] = 7'b0000001; pats[11] = 7'b0000000;
    pats[12] = 7'b1000000;
    for (int i = 0; i < 10; i++) codes[i] = 4'(i);
    codes[10] = 4'hF;
    codes[11] = 4'hD;

    vecs[0] = '{1, 2, 3, 4, 6,  16'h4321, 1'b0, 1};
    vecs[1] = '{1, 2, 3, 4, 20, 16'h4321, 1'b0, 1};
    vecs[2] = '{7, 7, 7, 7, 4,  16'h7777, 1'b0, 1};
    vecs[3] = '{9, 0, 10, 11, 5, 16'hDF09, 1'b0, 1};
    vecs[4] = '{8, 8, 12, 8, 6, 16'h8E88, 1'b1, 1};
    vecs[5] = '{6, 5, 2, 0, 6,  16'h0256, 1'b1, 1};

    mRun = 0; mPrevDig = 4'd0; mPrevSeg = 7'd0; mSeen = 4'd0; mFv = 1'b0; mErr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mShadow[i] = 4'hF;
      mX[i]      = 4'hF;
    end

    // Reset then idle
    applyStimulus(4'd0, 7'd0, 1'b0, 1'b1);
    applyStimulus(4'd0, 7'd0, 1'b0, 1'b1);
    frameCnt = 0;
    for (int k = 0; k < 20; k++) applyStimulus(4'd0, 7'd0, 1'b0, 1'b0);
    checkVal("idle_x", {o_x3, o_x2, o_x1, o_x0}, 16'hFFFF);
    checkVal("idle_err", o_err, 1'b0);
    checkVal("idle_frames", frameCnt, 0);

    // Table-driven scans
    for (int v = 0; v < 6; v++) begin
      scanDigits(vecs[v].c0, vecs[v].c1, vecs[v].c2, vecs[v].c3, vecs[v].hold);
      checkVal($sformatf("scan%0d_x", v), {o_x3, o_x2, o_x1, o_x0}, vecs[v].expX);
      checkVal($sformatf("scan%0d_err", v), o_err, vecs[v].expErr);
      checkVal($sformatf("scan%0d_frames", v), frameCnt, vecs[v].expFrames);
    end

    // err_clr pulse clears the sticky flag
    applyStimulus(4'd0, 7'd0, 1'b1, 1'b0);
    checkVal("err_clr", o_err, 1'b0);

    // err_clr coincident with a bad capture: set wins
    frameCnt = 0;
    holdDigit(0, 3, 6);
    holdDigit(1, 3, 6);
    for (int k = 0; k < 3; k++) applyStimulus(4'b0100, pats[12], 1'b0, 1'b0);
    applyStimulus(4'b0100, pats[12], 1'b1, 1'b0);
    checkVal("err_set_wins", o_err, 1'b1);
    holdDigit(3, 3, 6);
    checkVal("bad2_x", {o_x3, o_x2, o_x1, o_x0}, 16'h3E33);
    checkVal("bad2_frames", frameCnt, 1);

    // Glitch: 3-cycle pattern 8 must not be captured
    frameCnt = 0;
    holdDigit(0, 8, 3);
    holdDigit(0, 5, 5);
    holdDigit(1, 1, 6);
    holdDigit(2, 1, 6);
    holdDigit(3, 1, 6);
    checkVal("glitch_x", {o_x3, o_x2, o_x1, o_x0}, 16'h1115);
    checkVal("glitch_frames", frameCnt, 1);

    // Multi-hot enables are ignored
    frameCnt = 0;
    for (int k = 0; k < 10; k++) applyStimulus(4'b0011, pats[8], 1'b0, 1'b0);
    checkVal("multihot_frames", frameCnt, 0);
    scanDigits(9, 0, 10, 11, 5);
    checkVal("multihot_x", {o_x3, o_x2, o_x1, o_x0}, 16'hDF09);

    // Reset after three captures, then a clean scan
    holdDigit(0, 8, 6);
    holdDigit(1, 8, 6);
    holdDigit(2, 8, 6);
    applyStimulus(4'd0, 7'd0, 1'b0, 1'b1);
    checkVal("rst_mid_x", {o_x3, o_x2, o_x1, o_x0}, 16'hFFFF);
    checkVal("rst_mid_err", o_err, 1'b0);
    scanDigits(7, 7, 7, 7, 6);
    checkVal("after_rst_x", {o_x3, o_x2, o_x1, o_x0}, 16'h7777);
    checkVal("after_rst_frames", frameCnt, 1);

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) applyStimulus(4'd0, 7'd0, 1'b0, 1'b1);
      if ($urandom_range(0, 4) == 0) rd = 4'($urandom_range(0, 15));
      else rd = 4'd1 << $urandom_range(0, 3);
      if ($urandom_range(0, 4) == 0) rs = 7'($urandom_range(0, 127));
      else rs = pats[$urandom_range(0, 11)];
      hl = $urandom_range(1, 8);
      for (int k = 0; k < hl; k++) begin
        applyStimulus(rd, rs, ($urandom_range(0, 9) == 0), 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
